// File: rtl/hack_pkg.sv
// Shared constants and types for the Hack memory/IO block.
package hack_pkg;
  localparam int WORD_W = 16;

  localparam logic [WORD_W-1:0] ADDR_LED     = 16'h1000;
  localparam logic [WORD_W-1:0] ADDR_BUT     = 16'h1001;
  localparam logic [WORD_W-1:0] ADDR_UART_TX = 16'h1002;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_t;
endpackage

// File: rtl/hack_memory_io_uart_tx.sv
// 8N1 UART transmitter; one bit lasts BAUD_DIV clk cycles, start accepted only in IDLE.
module uart_tx
  import hack_pkg::*;
#(
  parameter int BAUD_DIV = 217
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] data,
  input  logic       start,
  output logic       busy,
  output logic       tx
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  uart_state_t   state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          bit_end;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= UART_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    bit_end = (baud_q == BAUD_LAST);
    unique case (state_q)
      UART_IDLE: begin
        if (start) begin
          state_d = UART_START;
          shreg_d = data;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      UART_START: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = UART_DATA;
        end else baud_d = baud_q + 1'b1;
      end
      UART_DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shreg_d = shreg_q >> 1;
          if (bit_q == 3'd7) state_d = UART_STOP;
          else bit_d = bit_q + 3'd1;
        end else baud_d = baud_q + 1'b1;
      end
      UART_STOP: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = UART_IDLE;
        end else baud_d = baud_q + 1'b1;
      end
      default: state_d = UART_IDLE;
    endcase
  end

  // Line is decoded from state so an async reset forces it high without waiting for a clock.
  always_comb begin
    busy = (state_q != UART_IDLE);
    tx   = 1'b1;
    if (state_q == UART_START) tx = 1'b0;
    else if (state_q == UART_DATA) tx = shreg_q[0];
  end
endmodule

// File: rtl/hack_memory_io.sv
// Hack data-memory map: RAM, LED register, synchronized buttons, optional UART TX.
// Build with UART_TX_EN defined to include the transmitter at 0x1002.
module hack_memory_io
  import hack_pkg::*;
#(
  parameter int RAM_DEPTH = 2048,
  parameter int BAUD_DIV  = 217
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WORD_W-1:0] addressM,
  input  logic [WORD_W-1:0] outM,
  input  logic              writeM,
  output logic [WORD_W-1:0] inM,
  input  logic [1:0]        but,
  output logic [1:0]        led,
  output logic              uart_tx
);
  localparam int AW = $clog2(RAM_DEPTH);
  localparam logic [14:0] RAM_TOP = 15'(RAM_DEPTH);

  logic [14:0] a;
  logic        is_ram;
  logic        unused_hi;
  logic [1:0]  but_meta, but_sync;
  logic [WORD_W-1:0] mem [RAM_DEPTH];

  assign a         = addressM[14:0];
  assign unused_hi = addressM[15];
  assign is_ram    = (a < RAM_TOP);

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (writeM && is_ram) mem[a[AW-1:0]] <= outM;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led      <= '0;
      but_meta <= '0;
      but_sync <= '0;
    end else begin
      if (writeM && a == ADDR_LED[14:0]) led <= outM[1:0];
      but_meta <= but;
      but_sync <= but_meta;
    end
  end

`ifdef UART_TX_EN
  logic busy;
  logic start;

  assign start = writeM && (a == ADDR_UART_TX[14:0]) && !busy;

  uart_tx #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk    (clk),
    .reset_n(reset_n),
    .data   (outM[7:0]),
    .start  (start),
    .busy   (busy),
    .tx     (uart_tx)
  );
`else
  assign uart_tx = 1'b1;
`endif

  always_comb begin
    inM = '0;
    if (is_ram) inM = mem[a[AW-1:0]];
    else if (a == ADDR_LED[14:0]) inM = {14'b0, led};
    else if (a == ADDR_BUT[14:0]) inM = {14'b0, but_sync};
`ifdef UART_TX_EN
    else if (a == ADDR_UART_TX[14:0]) inM = {15'b0, busy};
`endif
  end
endmodule

// File: tb/tb_hack_memory_io.sv
// Directed + randomized bench for hack_memory_io against a memory-map reference model.
module tb_hack_memory_io;
  localparam int RAM_DEPTH = 2048;
  localparam int BAUD_DIV  = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] addressM = '0;
  logic [15:0] outM = '0;
  logic        writeM = 1'b0;
  logic [15:0] inM;
  logic [1:0]  but = '0;
  logic [1:0]  led;
  logic        uart_tx;

  int checks = 0;
  int errors = 0;

  logic [15:0] ram_m [int];
  int          wr_q [$];
  logic [1:0]  led_m = '0;
  logic [1:0]  but_m = '0;

  hack_memory_io #(.RAM_DEPTH(RAM_DEPTH), .BAUD_DIV(BAUD_DIV)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .addressM(addressM),
    .outM    (outM),
    .writeM  (writeM),
    .inM     (inM),
    .but     (but),
    .led     (led),
    .uart_tx (uart_tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_rd(input logic [15:0] addr);
    int off = int'(addr[14:0]);
    if (off < RAM_DEPTH) return ram_m.exists(off) ? ram_m[off] : 16'hxxxx;
    if (off == 'h1000) return {14'b0, led_m};
    if (off == 'h1001) return {14'b0, but_m};
    return 16'h0000;
  endfunction

  task automatic model_wr(input logic [15:0] addr, input logic [15:0] d);
    int off = int'(addr[14:0]);
    if (off < RAM_DEPTH) begin
      ram_m[off] = d;
      wr_q.push_back(off);
    end else if (off == 'h1000) led_m = d[1:0];
  endtask

  // Called just after a rising edge; the bus transfer happens at the next one.
  task automatic cyc(input logic [15:0] addr, input logic [15:0] d, input logic w);
    addressM = addr;
    outM     = d;
    writeM   = w;
    @(posedge clk);
    #1;
    writeM = 1'b0;
  endtask

  task automatic readchk(input string tag, input logic [15:0] addr);
    addressM = addr;
    writeM   = 1'b0;
    #1;
    chk(tag, inM, model_rd(addr));
  endtask

  function automatic logic [15:0] rand_addr();
    logic [15:0] r;
    case ($urandom_range(0, 5))
      0, 1:    r = 16'($urandom_range(0, RAM_DEPTH - 1));
      2:       r = 16'h1000;
      3:       r = 16'h1001;
      4:       r = 16'($urandom_range(RAM_DEPTH, 'h0FFF));
      default: r = 16'($urandom_range('h1003, 'h7FFF));
    endcase
    r[15] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  initial begin
    logic [15:0] a, d, exp;
    logic        w;
    logic [9:0]  frame;

    #3;
    chk("rst_led", {14'b0, led}, 16'h0000);
    chk("rst_tx", {15'b0, uart_tx}, 16'h0001);
    addressM = 16'h1001;
    #1;
    chk("rst_but", inM, 16'h0000);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // RAM write/read including upper boundary and first unmapped word
    cyc(16'h0005, 16'hBEEF, 1'b1); model_wr(16'h0005, 16'hBEEF);
    cyc(16'h07FF, 16'h1234, 1'b1); model_wr(16'h07FF, 16'h1234);
    readchk("ram_5", 16'h0005);
    readchk("ram_7ff", 16'h07FF);
    readchk("ram_unmapped_800", 16'h0800);

    // LED register
    cyc(16'h1000, 16'hFFFF, 1'b1); model_wr(16'h1000, 16'hFFFF);
    chk("led_set", {14'b0, led}, {14'b0, led_m});
    readchk("led_rd", 16'h1000);
    cyc(16'h1000, 16'h0000, 1'b0);
    chk("led_nowrite", {14'b0, led}, 16'h0003);

    // Button synchronizer latency and write-ignore
    but = 2'b10;
    addressM = 16'h1001;
    #1;
    chk("but_lat0", inM, 16'h0000);
    @(posedge clk); #1;
    chk("but_lat1", inM, 16'h0000);
    @(posedge clk); #1;
    chk("but_lat2", inM, 16'h0002);
    but_m = 2'b10;
    cyc(16'h1001, 16'h0001, 1'b1); model_wr(16'h1001, 16'h0001);
    readchk("but_wr_ignored", 16'h1001);

`ifdef UART_TX_EN
    addressM = 16'h1002;
    #1;
    chk("uart_idle_busy", inM, 16'h0000);
    frame = {1'b1, 8'h41, 1'b0};
    cyc(16'h1002, 16'h0041, 1'b1);
    for (int i = 0; i < 10 * BAUD_DIV; i++) begin
      #1;
      chk("uart_bit", {15'b0, uart_tx}, {15'b0, frame[i / BAUD_DIV]});
      chk("uart_busy", inM, 16'h0001);
      outM   = 16'h0055;
      writeM = (i == 10);
      @(posedge clk); #1;
    end
    writeM = 1'b0;
    #1;
    chk("uart_done_busy", inM, 16'h0000);
    chk("uart_done_tx", {15'b0, uart_tx}, 16'h0001);
    // First idle cycle must already accept a new byte.
    cyc(16'h1002, 16'h005A, 1'b1);
    #1;
    chk("uart_b2b_tx", {15'b0, uart_tx}, 16'h0000);
    chk("uart_b2b_busy", inM, 16'h0001);
    repeat (BAUD_DIV + 6) @(posedge clk);
    #1;
`else
    cyc(16'h1002, 16'h0041, 1'b1);
    for (int i = 0; i < 12; i++) begin
      chk("notx_line", {15'b0, uart_tx}, 16'h0001);
      @(posedge clk); #1;
    end
    readchk("notx_rd", 16'h1002);
`endif

    // Asynchronous reset mid-operation
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_led", {14'b0, led}, 16'h0000);
    chk("arst_tx", {15'b0, uart_tx}, 16'h0001);
    led_m = '0;
    but_m = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    addressM = 16'h0005;
    #1;
    chk("ram_kept", inM, 16'hBEEF);
    readchk("ram_kept_hi", 16'h07FF);

    // Randomized traffic with buttons held steady
    but = 2'b01;
    repeat (3) @(posedge clk);
    #1;
    but_m = 2'b01;
    for (int n = 0; n < 60; n++) begin
      a = rand_addr();
      d = 16'($urandom);
      w = 1'($urandom_range(0, 1));
      cyc(a, d, w);
      if (w) model_wr(a, d);
      exp = model_rd(a);
      if (!$isunknown(exp)) readchk("rnd_same", a);
      if (wr_q.size() > 0)
        readchk("rnd_ram", 16'(wr_q[$urandom_range(0, wr_q.size() - 1)]));
      chk("rnd_led", {14'b0, led}, {14'b0, led_m});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
